// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU controller:
//   - opcode constants for the shared ALU datapath
//   - issue FSM state encodings
//   - bit positions of the {Z, V, N} flag register
//   - flag-update class per opcode and the address-result selector
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_RED    = 4'd2;
    localparam logic [3:0] OP_XOR    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_SRA    = 4'd5;
    localparam logic [3:0] OP_ROR    = 4'd6;
    localparam logic [3:0] OP_PADDSB = 4'd7;
    localparam logic [3:0] OP_LW     = 4'd8;
    localparam logic [3:0] OP_SW     = 4'd9;
    localparam logic [3:0] OP_LLB    = 4'd10;
    localparam logic [3:0] OP_LHB    = 4'd11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC1 = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Flag-update classes
    localparam logic [1:0] FC_NONE = 2'd0;  // flags held
    localparam logic [1:0] FC_Z    = 2'd1;  // Z only, V/N held
    localparam logic [1:0] FC_ZVN  = 2'd2;  // Z, V and N

    function automatic logic [1:0] flag_class(input logic [3:0] op);
        logic [1:0] fc;
        case (op)
            OP_ADD, OP_SUB:                 fc = FC_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z;
            default:                        fc = FC_NONE;
        endcase
        return fc;
    endfunction

    // Opcodes 8..11 take their result from the ALU address path.
    function automatic logic uses_addr(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// ---------------------------------------------------------------------------
// alu_flag_reg
// Architectural {Z, V, N} flag register with per-opcode update decode.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (flags clear to 0)
//   upd_i        an op retires this cycle
//   opcode_i     opcode of the retiring op
//   result_i     result being written to the output register
//   v_i          adder overflow for the retiring op
//   flags_o      {Z, V, N}
// ---------------------------------------------------------------------------
module alu_flag_reg
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         upd_i,
    input  logic [3:0]   opcode_i,
    input  logic [W-1:0] result_i,
    input  logic         v_i,
    output logic [2:0]   flags_o
);

    logic [2:0] flags_q;
    logic [2:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (upd_i) begin
            case (flag_class(opcode_i))
                FC_ZVN: begin
                    flags_d[FLAG_Z] = (result_i == '0);
                    flags_d[FLAG_V] = v_i;
                    flags_d[FLAG_N] = result_i[W-1];
                end
                FC_Z: begin
                    flags_d[FLAG_Z] = (result_i == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// EX-stage controller for the shared ALU. Takes one op per handshake from
// decode, holds its operands on the ALU for 1 or 2 cycles (MC_MASK selects
// 2-cycle opcodes), registers the result for MEM and updates the flags.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               decode handshake
//   in_opcode, in_a, in_b, in_dst   op from decode
//   flush                           kill the in-flight op
//   alu_a, alu_b, alu_opcode        held operands to the ALU
//   alu_result, alu_addr, alu_v     ALU results
//   out_valid/out_ready             MEM handshake
//   out_result, out_dst, out_opcode registered result
//   flags                           {Z, V, N}
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter logic [15:0] MC_MASK = 16'h0084,
    parameter int          W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_opcode,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [3:0]   in_dst,
    input  logic         flush,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    input  logic [W-1:0] alu_result,
    input  logic [W-1:0] alu_addr,
    input  logic         alu_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_dst,
    output logic [3:0]   out_opcode,
    output logic [2:0]   flags
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [3:0]   op_q, op_d;
    logic [3:0]   dst_q, dst_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_result_q, out_result_d;
    logic [3:0]   out_dst_q, out_dst_d;
    logic [3:0]   out_opcode_q, out_opcode_d;

    logic         retire;
    logic         accept;
    logic [W-1:0] retire_result;

    assign retire        = (state_q == ST_EXEC) && !flush && (!out_valid_q || out_ready);
    assign retire_result = uses_addr(op_q) ? alu_addr : alu_result;

    // A retiring op frees the operand latches, so a new op can be taken in
    // the same cycle for back-to-back throughput.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = !flush;
            ST_EXEC: in_ready = retire;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = MC_MASK[in_opcode] ? ST_EXEC1 : ST_EXEC;
                ST_EXEC1: state_d = ST_EXEC;
                ST_EXEC: begin
                    if (retire) begin
                        if (accept) state_d = MC_MASK[in_opcode] ? ST_EXEC1 : ST_EXEC;
                        else        state_d = ST_IDLE;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        a_d   = accept ? in_a      : a_q;
        b_d   = accept ? in_b      : b_q;
        op_d  = accept ? in_opcode : op_q;
        dst_d = accept ? in_dst    : dst_q;
    end

    // Output register: data only changes on retire; valid drops on a
    // transfer that is not refilled in the same cycle.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_dst_d    = out_dst_q;
        out_opcode_d = out_opcode_q;
        if (retire) begin
            out_valid_d  = 1'b1;
            out_result_d = retire_result;
            out_dst_d    = dst_q;
            out_opcode_d = op_q;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            dst_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dst_q    <= '0;
            out_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            dst_q        <= dst_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_dst_q    <= out_dst_d;
            out_opcode_q <= out_opcode_d;
        end
    end

    alu_flag_reg #(.W(W)) u_flag_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_i    (retire),
        .opcode_i (op_q),
        .result_i (retire_result),
        .v_i      (alu_v),
        .flags_o  (flags)
    );

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dst    = out_dst_q;
    assign out_opcode = out_opcode_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl: directed scenarios followed by a randomized run
// scored against a transaction-level model (in-order result queue plus a
// running flag value). A small behavioural ALU stands in for the datapath.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_dst;
    logic        flush;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_result, alu_addr;
    logic        alu_v;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_dst, out_opcode;
    logic [2:0]  flags;

    int nvec;
    int nerr;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  dst;
        logic [3:0]  op;
        logic [2:0]  fl;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [2:0]  model_flags;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MC_MASK(16'h0084), .W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_dst     (in_dst),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_addr   (alu_addr),
        .alu_v      (alu_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dst    (out_dst),
        .out_opcode (out_opcode),
        .flags      (flags)
    );

    function automatic logic [7:0] sat8(input logic [7:0] x, input logic [7:0] y);
        logic signed [8:0] s;
        s = $signed({x[7], x}) + $signed({y[7], y});
        if (s > 9'sd127)       return 8'h7F;
        else if (s < -9'sd128) return 8'h80;
        else                   return s[7:0];
    endfunction

    function automatic logic [15:0] stub_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] rr;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return 16'(a[7:0] + a[15:8] + b[7:0] + b[15:8]);
            4'd3:    return a ^ b;
            4'd4:    return a << b[3:0];
            4'd5:    return 16'($signed(a) >>> b[3:0]);
            4'd6: begin
                rr = {a, a} >> b[3:0];
                return rr[15:0];
            end
            4'd7:    return {sat8(a[15:8], b[15:8]), sat8(a[7:0], b[7:0])};
            default: return {b[7:0], a[7:0]};
        endcase
    endfunction

    function automatic logic stub_v(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        if (op == 4'd0) begin
            s = a + b;
            return (a[15] == b[15]) && (s[15] != a[15]);
        end else if (op == 4'd1) begin
            s = a - b;
            return (a[15] != b[15]) && (s[15] != a[15]);
        end
        return 1'b0;
    endfunction

    // Stand-in ALU driven by the controller's held operands.
    always_comb begin
        alu_result = stub_res(alu_opcode, alu_a, alu_b);
        alu_addr   = alu_a + alu_b;
        alu_v      = stub_v(alu_opcode, alu_a, alu_b);
    end

    // Reference: result visible to MEM for an op, from the opcode rules.
    function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op >= 4'd8 && op <= 4'd11) return a + b;
        return stub_res(op, a, b);
    endfunction

    // Reference: flags after an op retires.
    function automatic logic [2:0] ref_flags(input logic [2:0] f, input logic [3:0] op,
                                             input logic [15:0] r, input logic v);
        if (op <= 4'd1)                return {r == 16'h0, v, r[15]};
        if (op >= 4'd3 && op <= 4'd6)  return {r == 16'h0, f[1], f[0]};
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        nvec++;
        assert (obs === req) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_dst    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
        in_dst = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // ADD producing zero
        issue(OP_ADD, 16'h0001, 16'hFFFF, 4'd3);
        #1 chk("add_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        chk("add_lat_not_yet", out_valid, 0);
        chk("add_alu_a", alu_a, 16'h0001);
        chk("add_alu_b", alu_b, 16'hFFFF);
        tick();
        chk("add_out_valid", out_valid, 1);
        chk("add_out_result", out_result, 16'h0000);
        chk("add_out_dst", out_dst, 3);
        chk("add_flags", flags, 3'b100);

        // SUB overflow, then XOR holds V/N
        issue(OP_SUB, 16'h8000, 16'h0001, 4'd4);
        tick(); in_valid = 1'b0;
        chk("sub_xfer_drop", out_valid, 0);
        tick();
        chk("sub_result", out_result, 16'h7FFF);
        chk("sub_flags", flags, 3'b010);
        issue(OP_XOR, 16'h00F0, 16'h000F, 4'd5);
        tick(); in_valid = 1'b0;
        tick();
        chk("xor_result", out_result, 16'h00FF);
        chk("xor_flags", flags, 3'b010);

        // PADDSB (2-cycle) with a following ADD stream
        issue(OP_PADDSB, 16'h7F01, 16'h0101, 4'd6);
        tick();
        issue(OP_ADD, 16'h0010, 16'h0020, 4'd7);
        #1;
        chk("mc_exec1_ready", in_ready, 0);
        chk("mc_exec1_valid", out_valid, 0);
        tick();
        chk("mc_exec_ready", in_ready, 1);
        chk("mc_exec_valid", out_valid, 0);
        tick();
        chk("mc_out_valid", out_valid, 1);
        chk("mc_result", out_result, 16'h7F02);
        chk("mc_opcode", out_opcode, OP_PADDSB);
        chk("mc_flags", flags, 3'b010);
        issue(OP_ADD, 16'h0030, 16'h0040, 4'd8);
        tick();
        chk("b2b_1_result", out_result, 16'h0030);
        chk("b2b_1_dst", out_dst, 7);
        chk("b2b_1_flags", flags, 3'b000);
        issue(OP_ADD, 16'hFFFF, 16'hFFFF, 4'd9);
        tick();
        chk("b2b_2_result", out_result, 16'h0070);
        in_valid = 1'b0;
        tick();
        chk("b2b_3_result", out_result, 16'hFFFE);
        chk("b2b_3_flags", flags, 3'b001);
        tick();
        chk("b2b_drain", out_valid, 0);

        // Backpressure with two ops
        out_ready = 1'b0;
        issue(OP_ADD, 16'h0003, 16'h0004, 4'd1);
        tick();
        issue(OP_XOR, 16'h0005, 16'h0006, 4'd2);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 16'h0007);
            chk("bp_alu_a", alu_a, 16'h0005);
            chk("bp_alu_b", alu_b, 16'h0006);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_result", out_result, 16'h0003);
        chk("bp_second_dst", out_dst, 2);
        chk("bp_flags", flags, 3'b000);
        tick();
        chk("bp_drain", out_valid, 0);

        // Flush during EXEC1 of RED
        issue(OP_RED, 16'h1234, 16'h1111, 4'd3);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_no_valid", out_valid, 0);
        chk("flush_flags", flags, 3'b000);
        chk("flush_idle_ready", in_ready, 1);
        tick();
        chk("flush_still_no_valid", out_valid, 0);
        // flush beats in_valid in IDLE
        flush = 1'b1;
        issue(OP_ADD, 16'h0000, 16'h0000, 4'd4);
        #1 chk("flush_wins_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1 chk("post_flush_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        chk("post_flush_opcode", alu_opcode, OP_ADD);
        chk("post_flush_lat", out_valid, 0);
        tick();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_result", out_result, 16'h0000);
        chk("post_flush_flags", flags, 3'b100);

        // Asynchronous reset mid-EXEC with a held result
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        issue(OP_SUB, 16'h8000, 16'h0001, 4'd5);
        tick();
        issue(OP_ADD, 16'h0002, 16'h0002, 4'd6);
        tick(); in_valid = 1'b0;
        chk("arst_pre_valid", out_valid, 1);
        chk("arst_pre_result", out_result, 16'h7FFF);
        chk("arst_pre_flags", flags, 3'b010);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_result", out_result, 0);
        chk("arst_flags", flags, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_dst", out_dst, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Randomized run against the transaction model
        model_flags = 3'b000;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_opcode = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       in_a = 16'h8000;
                1:       in_a = 16'h7FFF;
                default: in_a = 16'($urandom);
            endcase
            in_b      = ($urandom_range(0, 3) == 0) ? 16'(-in_a) : 16'($urandom);
            in_dst    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_valid", out_valid, 0);
                end else begin
                    e = q[0];
                    chk("rnd_flags", flags, e.fl);
                    if (out_ready) begin
                        chk("rnd_result", out_result, e.res);
                        chk("rnd_dst", out_dst, e.dst);
                        chk("rnd_opcode", out_opcode, e.op);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.res = ref_res(in_opcode, in_a, in_b);
                model_flags = ref_flags(model_flags, in_opcode, e.res,
                                        stub_v(in_opcode, in_a, in_b));
                e.dst = in_dst;
                e.op  = in_opcode;
                e.fl  = model_flags;
                q.push_back(e);
            end
            tick();
        end

        // Drain, bounded
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("drain_unexpected_valid", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("drain_result", out_result, e.res);
                    chk("drain_dst", out_dst, e.dst);
                    chk("drain_flags", flags, e.fl);
                end
            end
            tick();
        end
        chk("drain_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
